// File: rtl/unified_mem_arbiter.sv
// Arbiter granting one of NUM_PORTS requesters access to a single-ported memory.
// Losing requesters are held off with a combinational per-port stall.
module unified_mem_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_LAT   = 1,
  parameter int RR_MODE   = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            req,
  input  logic [NUM_PORTS-1:0]            we,
  input  logic [NUM_PORTS*ADDR_W-1:0]     addr,
  input  logic [NUM_PORTS*DATA_W-1:0]     wdata,
  input  logic [NUM_PORTS*(DATA_W/8)-1:0] wstrb,
  output logic [NUM_PORTS-1:0]            ack,
  output logic [NUM_PORTS-1:0]            stall,
  output logic [DATA_W-1:0]               rdata,
  output logic                            mem_en,
  output logic                            mem_we,
  output logic [ADDR_W-1:0]               mem_addr,
  output logic [DATA_W-1:0]               mem_wdata,
  output logic [DATA_W/8-1:0]             mem_wstrb,
  input  logic [DATA_W-1:0]               mem_rdata
);

  // state  | meaning
  // IDLE   | no access in flight; grant the next winner on this edge
  // ACCESS | memory command held on mem_*; counter runs down to 0
  // DONE   | ack pulse to the granted port; always returns to IDLE

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = $clog2(NUM_PORTS);
  localparam int CNT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   grant_idx;

  logic [IDX_W-1:0]   search_start;
  logic [IDX_W:0]     probe;
  logic [IDX_W-1:0]   win_idx;
  logic               win_found;
  logic [IDX_W-1:0]   next_ptr;

  // Circular search from the start index; fixed priority always starts at 0.
  always_comb begin
    search_start = (RR_MODE != 0) ? rr_ptr : '0;
    probe        = '0;
    win_idx      = '0;
    win_found    = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      probe = {1'b0, search_start} + (IDX_W+1)'(k);
      if (probe >= (IDX_W+1)'(NUM_PORTS))
        probe = probe - (IDX_W+1)'(NUM_PORTS);
      if (!win_found && req[probe[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = probe[IDX_W-1:0];
      end
    end
  end

  assign next_ptr = (win_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : win_idx + 1'b1;
  assign stall    = req & ~ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rr_ptr    <= '0;
      grant_idx <= '0;
      ack       <= '0;
      rdata     <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack <= '0;
          if (win_found) begin
            grant_idx <= win_idx;
            rr_ptr    <= next_ptr;
            mem_en    <= 1'b1;
            mem_we    <= we[win_idx];
            mem_addr  <= addr[win_idx*ADDR_W +: ADDR_W];
            mem_wdata <= wdata[win_idx*DATA_W +: DATA_W];
            mem_wstrb <= wstrb[win_idx*STRB_W +: STRB_W];
            cnt       <= CNT_W'(MEM_LAT - 1);
            state     <= ACCESS;
          end else begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            // writes leave the last read value visible on rdata
            if (!mem_we)
              rdata <= mem_rdata;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            ack    <= NUM_PORTS'(1) << grant_idx;
            state  <= DONE;
          end
        end
        DONE: begin
          ack   <= '0;
          state <= IDLE;
        end
        default: begin
          ack   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench: two arbiter configurations (fixed priority, round robin)
// share random stimulus; a transaction-level model predicts each grant.
module tb_unified_mem_arbiter;

  localparam int NP = 3;

  typedef struct {
    int          port;
    int          grant;
    int          ackc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
  } txn_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NP-1:0]   req = '0;
  logic [NP-1:0]   we = '0;
  logic [NP*32-1:0] addr = '0;
  logic [NP*32-1:0] wdata = '0;
  logic [NP*4-1:0]  wstrb = '0;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction

  function automatic int pick(input logic [NP-1:0] r, input int ptr, input bit rr);
    int start;
    start = rr ? ptr : 0;
    for (int k = 0; k < NP; k++)
      if (r[(start + k) % NP]) return (start + k) % NP;
    return -1;
  endfunction

  task automatic chk(input int g, input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL cfg%0d %s @cycle %0d: got %0h expected %0h", g, nm, cyc, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int L  = (g == 0) ? 2 : 1;
    localparam bit RR = (g == 1);

    logic [NP-1:0] ack, stall;
    logic [31:0]   rdata, mem_addr, mem_wdata, mem_rdata;
    logic          mem_en, mem_we;
    logic [3:0]    mem_wstrb;

    txn_t q[$];
    int   ptr = 0;
    int   free_at = 0;
    int   nacks = 0;
    logic [31:0] last_rd = '0;

    unified_mem_arbiter #(
      .NUM_PORTS(NP), .ADDR_W(32), .DATA_W(32), .MEM_LAT(L), .RR_MODE(RR ? 1 : 0)
    ) dut (
      .clk(clk), .rst(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .wstrb(wstrb), .ack(ack), .stall(stall), .rdata(rdata), .mem_en(mem_en),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
    );

    assign mem_rdata = memfn(mem_addr);

    // Model: the memory is free again MEM_LAT+2 cycles after each grant.
    always @(posedge clk) begin
      txn_t tx;
      int   w;
      if (!rst_n) begin
        q.delete();
        ptr     = 0;
        free_at = cyc + 1;
        last_rd = '0;
      end else if (cyc >= free_at && req != '0) begin
        w        = pick(req, ptr, RR);
        tx.port  = w;
        tx.grant = cyc;
        tx.ackc  = cyc + L + 1;
        tx.we    = we[w];
        tx.addr  = addr[w*32 +: 32];
        tx.wdata = wdata[w*32 +: 32];
        tx.wstrb = wstrb[w*4 +: 4];
        tx.rdata = tx.we ? last_rd : memfn(tx.addr);
        if (!tx.we) last_rd = tx.rdata;
        q.push_back(tx);
        ptr     = (w + 1) % NP;
        free_at = cyc + L + 2;
      end
    end

    always @(negedge clk) begin
      logic [NP-1:0] exp_ack;
      logic          exp_en;
      txn_t          h;
      exp_ack = '0;
      exp_en  = 1'b0;
      if (!rst_n) begin
        chk(g, "reset_outputs",
            {ack, rdata, mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb}, '0);
      end else begin
        if (q.size() > 0) begin
          h = q[0];
          if (cyc == h.ackc) exp_ack = NP'(1) << h.port;
          if (cyc > h.grant && cyc <= h.grant + L) exp_en = 1'b1;
        end
        chk(g, "ack", ack, exp_ack);
        chk(g, "stall", stall, req & ~exp_ack);
        chk(g, "mem_en", mem_en, exp_en);
        if (exp_en) begin
          chk(g, "mem_cmd", {mem_we, mem_addr, mem_wdata, mem_wstrb},
              {h.we, h.addr, h.wdata, h.wstrb});
        end else begin
          chk(g, "mem_we_idle", mem_we, 1'b0);
        end
        if (exp_ack != '0) begin
          chk(g, "rdata", rdata, h.rdata);
          nacks++;
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_port(input int p, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s);
    we[p]          = w;
    addr[p*32 +: 32] = a;
    wdata[p*32 +: 32] = d;
    wstrb[p*4 +: 4]  = s;
  endtask

  task automatic random_phase(input int n);
    repeat (n) begin
      step(1);
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(3) == 0) req[p] = ~req[p];
        if ($urandom_range(1) == 1)
          set_port(p, 1'($urandom_range(1)), $urandom, $urandom, 4'($urandom_range(15)));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(10);

    // sb-style byte write from port 0
    set_port(0, 1'b1, 32'h0000000A, 32'h0A0A0A0A, 4'b0100);
    req = 3'b001;
    step(1);
    req = 3'b000;
    step(8);

    // single read from port 1
    set_port(1, 1'b0, 32'h00000008, 32'h0, 4'hF);
    req = 3'b010;
    step(1);
    req = 3'b000;
    step(8);

    // two ports colliding on the same edge, held until served
    set_port(0, 1'b0, 32'h00000100, 32'h0, 4'hF);
    req = 3'b011;
    step(14);
    req = 3'b000;
    step(4);

    // all ports requesting continuously
    set_port(2, 1'b0, 32'h00000200, 32'h0, 4'hF);
    req = 3'b111;
    step(30);

    random_phase(400);

    // reset while accesses are in flight, requests held across it
    req = 3'b111;
    step(3);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(20);

    random_phase(300);

    req = 3'b000;
    step(12);

    chk(0, "ack_activity", 128'(cfg[0].nacks > 40), 128'(1));
    chk(1, "ack_activity", 128'(cfg[1].nacks > 40), 128'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Parametrised arbiter that lets NUM_PORTS pipeline requesters share one single-ported memory (e.g. instruction fetch and data access to a unified memory).
- Resolves the resulting structural hazard by granting one requester at a time and holding every other requester with a per-port stall.
- Sits between the pipeline and the memory array.
- Supports fixed-priority or round-robin arbitration, configurable memory latency, and byte-strobed writes (sb/sh/sw).

Parameters:
NUM_PORTS, 2, number of requesters (2..8); port 0 has highest fixed priority
ADDR_W, 32, byte address width
DATA_W, 32, data width (multiple of 8)
MEM_LAT, 1, cycles the memory command is held before read data is captured (>=1)
RR_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round robin

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-low reset (asserted when 0)
req  input  NUM_PORTS  per-port access request, held until ack
we  input  NUM_PORTS  per-port write enable
addr  input  NUM_PORTS*ADDR_W  packed per-port addresses, port i at [i*ADDR_W +: ADDR_W]
wdata  input  NUM_PORTS*DATA_W  packed per-port write data
wstrb  input  NUM_PORTS*(DATA_W/8)  packed per-port byte enables
ack  output  NUM_PORTS  one-cycle completion pulse, one-hot or zero
stall  output  NUM_PORTS  req[i] & ~ack[i], combinational
rdata  output  DATA_W  read data, valid while ack is high
mem_en  output  1  memory command valid
mem_we  output  1  memory write
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_wstrb  output  DATA_W/8  memory byte enables
mem_rdata  input  DATA_W  memory read data

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; counter 0; RR pointer 0; ack, rdata, mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb all 0. A reset during ACCESS or DONE aborts the access with no ack. Outputs remain at reset values until the first edge after rst returns to 1.
- States: IDLE, ACCESS, DONE.
- IDLE, at least one req bit high at the edge:
  - Select the winner.
  - Latch the winner's index, we, addr, wdata and wstrb into the mem_* registers.
  - Set mem_en=1 and counter=MEM_LAT-1, then go to ACCESS.
- IDLE with no request: stay in IDLE; all mem_* outputs 0.
- ACCESS: mem_* outputs hold constant.
  - counter>0: decrement.
  - counter==0: capture mem_rdata into rdata (reads only; writes leave rdata unchanged), clear mem_en and mem_we, go to DONE.
- DONE: ack[winner]=1 for exactly one cycle, then go to IDLE unconditionally.
- Latency: a request first sampled in IDLE acks MEM_LAT+1 cycles later. A competing request waits an additional MEM_LAT+2 cycles per access granted ahead of it.
- Back-to-back accesses: the earliest re-grant is the edge after DONE (one IDLE cycle between accesses). A requester still asserting req in the IDLE cycle is treated as a new request.
- Request changes mid-access: changes to req, addr or wdata during ACCESS or DONE are ignored.
- Fixed priority (RR_MODE=0): the lowest-index asserted req wins.
- Round robin (RR_MODE=1): search starts at the RR pointer and wraps modulo NUM_PORTS. On each grant the pointer becomes (winner+1) mod NUM_PORTS.
- Dropped request: a req that falls while waiting is simply not granted.
- stall is purely combinational; it is high on every cycle a port requests, except its ack cycle.
- Writes complete with an ack, the same as reads. The strobe pattern passes through unchanged.

Test Plan:
- Single read, MEM_LAT=2, port 1 req with addr=0x8 and mem_rdata=0x0000000A: mem_en high for 2 cycles, then ack[1] and rdata=0xA at cycle 3; stall[1] high for cycles 0-2.
- Structural conflict, RR_MODE=0, MEM_LAT=1, ports 0 and 1 request on the same edge: ack[0] at cycle 2, then ack[1] at cycle 5; stall[1] high throughout cycles 0-4.
- sb x2,0(x2) as port 0 write with addr=0xA, wdata=0x0A0A0A0A, wstrb=0b0100: mem_we=1, mem_addr=0xA, mem_wstrb=0b0100; rdata is unchanged at ack.
- Round robin, NUM_PORTS=3, all ports requesting continuously: grant order 0,1,2,0,1,2; each port acks once per 9 cycles with MEM_LAT=1.
- Reset mid-access: drive rst=0 during ACCESS → all outputs 0 immediately with no ack; after release a held req restarts from IDLE and the RR pointer is back at 0.
- No requests for 10 cycles: mem_en=0, ack=0, stall=0 throughout.
